// File: rtl/iob_eth_bd_arbiter.sv
// iob_eth_bd_arbiter
// Three-way arbiter sharing one single-port buffer-descriptor RAM between the
// CPU and the TX/RX DMA engines.
//   clk_i, arst_n_i, cke_i         : clock, async active-low reset, clock enable
//   {cpu,tx,rx}_req_i/_wen_i       : access request and direction (1=write)
//   {cpu,tx,rx}_addr_i/_wdata_i    : descriptor word address and write data
//   {cpu,tx,rx}_gnt_o              : access accepted this cycle (combinational)
//   {cpu,tx,rx}_rvalid_o           : read data valid on rdata_o
//   rdata_o                        : shared read data, straight from bd_i
//   bd_en_o/bd_wen_o/bd_addr_o/bd_o: RAM port; bd_i: RAM read data (1-cycle)
// CPU has priority over DMA unless it has already taken CPU_MAX_RUN grants in a
// row while DMA waits; TX and RX alternate when both request.
module iob_eth_bd_arbiter #(
    parameter int unsigned BD_ADDR_W   = 8,
    parameter int unsigned CPU_MAX_RUN = 4
) (
    input  logic                 clk_i,
    input  logic                 arst_n_i,
    input  logic                 cke_i,
    input  logic                 cpu_req_i,
    input  logic                 tx_req_i,
    input  logic                 rx_req_i,
    input  logic                 cpu_wen_i,
    input  logic                 tx_wen_i,
    input  logic                 rx_wen_i,
    input  logic [BD_ADDR_W-1:0] cpu_addr_i,
    input  logic [BD_ADDR_W-1:0] tx_addr_i,
    input  logic [BD_ADDR_W-1:0] rx_addr_i,
    input  logic [31:0]          cpu_wdata_i,
    input  logic [31:0]          tx_wdata_i,
    input  logic [31:0]          rx_wdata_i,
    output logic                 cpu_gnt_o,
    output logic                 tx_gnt_o,
    output logic                 rx_gnt_o,
    output logic                 cpu_rvalid_o,
    output logic                 tx_rvalid_o,
    output logic                 rx_rvalid_o,
    output logic [31:0]          rdata_o,
    output logic                 bd_en_o,
    output logic                 bd_wen_o,
    output logic [BD_ADDR_W-1:0] bd_addr_o,
    output logic [31:0]          bd_o,
    input  logic [31:0]          bd_i
);

    typedef enum logic {
        LAST_TX = 1'b0,
        LAST_RX = 1'b1
    } last_dma_t;

    localparam logic [3:0] MAX_RUN = 4'(CPU_MAX_RUN);

    last_dma_t  last_dma_q, last_dma_d;
    logic [3:0] cpu_run_q,  cpu_run_d;
    logic [2:0] rvalid_q,   rvalid_d;   // {rx, tx, cpu}

    logic dma_req, active, starve;
    logic cpu_win, dma_win, tx_win, rx_win;

    // Winner selection. Grants are suppressed while frozen or held in reset.
    always_comb begin
        dma_req = tx_req_i | rx_req_i;
        active  = cke_i & arst_n_i;
        starve  = dma_req & (cpu_run_q == MAX_RUN);
        cpu_win = active & cpu_req_i & ~starve;
        dma_win = active & dma_req & ~cpu_win;
        tx_win  = dma_win & tx_req_i & (~rx_req_i | (last_dma_q == LAST_RX));
        rx_win  = dma_win & ~tx_win;
    end

    // Next-state: everything holds while cke_i is low.
    always_comb begin
        last_dma_d = last_dma_q;
        cpu_run_d  = cpu_run_q;
        rvalid_d   = rvalid_q;
        if (cke_i) begin
            rvalid_d = {rx_win & ~rx_wen_i, tx_win & ~tx_wen_i, cpu_win & ~cpu_wen_i};
            if (tx_win) begin
                last_dma_d = LAST_TX;
            end else if (rx_win) begin
                last_dma_d = LAST_RX;
            end
            // The run only counts CPU grants that made a DMA requester wait.
            if (dma_win || !dma_req) begin
                cpu_run_d = '0;
            end else if (cpu_win) begin
                cpu_run_d = cpu_run_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            last_dma_q <= LAST_RX;
            cpu_run_q  <= '0;
            rvalid_q   <= '0;
        end else begin
            last_dma_q <= last_dma_d;
            cpu_run_q  <= cpu_run_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // RAM port mux; idle port is driven to all zeros.
    always_comb begin
        bd_en_o   = 1'b0;
        bd_wen_o  = 1'b0;
        bd_addr_o = '0;
        bd_o      = '0;
        if (cpu_win) begin
            bd_en_o   = 1'b1;
            bd_wen_o  = cpu_wen_i;
            bd_addr_o = cpu_addr_i;
            bd_o      = cpu_wdata_i;
        end else if (tx_win) begin
            bd_en_o   = 1'b1;
            bd_wen_o  = tx_wen_i;
            bd_addr_o = tx_addr_i;
            bd_o      = tx_wdata_i;
        end else if (rx_win) begin
            bd_en_o   = 1'b1;
            bd_wen_o  = rx_wen_i;
            bd_addr_o = rx_addr_i;
            bd_o      = rx_wdata_i;
        end
    end

    assign cpu_gnt_o = cpu_win;
    assign tx_gnt_o  = tx_win;
    assign rx_gnt_o  = rx_win;

    // A pending rvalid stays hidden while frozen and shows on the first
    // enabled cycle, so it is seen exactly once.
    assign cpu_rvalid_o = rvalid_q[0] & cke_i;
    assign tx_rvalid_o  = rvalid_q[1] & cke_i;
    assign rx_rvalid_o  = rvalid_q[2] & cke_i;
    assign rdata_o      = bd_i;

endmodule

// File: tb/tb_iob_eth_bd_arbiter.sv
module tb_iob_eth_bd_arbiter;

    localparam int unsigned AW   = 8;
    localparam int unsigned MAXR = 4;

    logic clk = 1'b0;
    logic arst_n, cke;
    logic cpu_req, tx_req, rx_req, cpu_wen, tx_wen, rx_wen;
    logic [AW-1:0] cpu_addr, tx_addr, rx_addr;
    logic [31:0] cpu_wdata, tx_wdata, rx_wdata;
    logic cpu_gnt_o, tx_gnt_o, rx_gnt_o;
    logic cpu_rvalid_o, tx_rvalid_o, rx_rvalid_o;
    logic [31:0] rdata_o, bd_o, bd_i;
    logic bd_en_o, bd_wen_o;
    logic [AW-1:0] bd_addr_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iob_eth_bd_arbiter #(.BD_ADDR_W(AW), .CPU_MAX_RUN(MAXR)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
        .cpu_req_i(cpu_req), .tx_req_i(tx_req), .rx_req_i(rx_req),
        .cpu_wen_i(cpu_wen), .tx_wen_i(tx_wen), .rx_wen_i(rx_wen),
        .cpu_addr_i(cpu_addr), .tx_addr_i(tx_addr), .rx_addr_i(rx_addr),
        .cpu_wdata_i(cpu_wdata), .tx_wdata_i(tx_wdata), .rx_wdata_i(rx_wdata),
        .cpu_gnt_o(cpu_gnt_o), .tx_gnt_o(tx_gnt_o), .rx_gnt_o(rx_gnt_o),
        .cpu_rvalid_o(cpu_rvalid_o), .tx_rvalid_o(tx_rvalid_o), .rx_rvalid_o(rx_rvalid_o),
        .rdata_o(rdata_o), .bd_en_o(bd_en_o), .bd_wen_o(bd_wen_o),
        .bd_addr_o(bd_addr_o), .bd_o(bd_o), .bd_i(bd_i)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Requesters are numbered 0=none, 1=CPU, 2=TX, 3=RX.
    int m_last_rx = 1;   // 1: RX was served last, so TX goes first
    int m_run     = 0;   // CPU grants taken while DMA waited
    int m_rv      = 0;   // requester owed read data next enabled cycle

    function automatic int m_winner();
        if (!cke || !arst_n) return 0;
        if (cpu_req && !((tx_req || rx_req) && m_run == MAXR)) return 1;
        if (tx_req && rx_req) return (m_last_rx == 1) ? 2 : 3;
        if (tx_req) return 2;
        if (rx_req) return 3;
        return 0;
    endfunction

    function automatic logic m_wen(input int w);
        return (w == 1) ? cpu_wen : (w == 2) ? tx_wen : rx_wen;
    endfunction

    function automatic logic [AW-1:0] m_addr(input int w);
        return (w == 1) ? cpu_addr : (w == 2) ? tx_addr : (w == 3) ? rx_addr : '0;
    endfunction

    function automatic logic [31:0] m_wdata(input int w);
        return (w == 1) ? cpu_wdata : (w == 2) ? tx_wdata : (w == 3) ? rx_wdata : '0;
    endfunction

    function automatic int dut_gnt();
        return cpu_gnt_o ? 1 : tx_gnt_o ? 2 : rx_gnt_o ? 3 : 0;
    endfunction

    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            m_last_rx = 1;
            m_run     = 0;
            m_rv      = 0;
        end else if (cke) begin
            int w;
            w = m_winner();
            m_rv = (w != 0 && !m_wen(w)) ? w : 0;
            if (w >= 2) m_last_rx = (w == 3) ? 1 : 0;
            if (w >= 2 || !(tx_req || rx_req)) m_run = 0;
            else if (w == 1) m_run = m_run + 1;
        end
    end

    always @(negedge clk) begin
        int w;
        w = m_winner();
        check("cpu_gnt", cpu_gnt_o, w == 1);
        check("tx_gnt", tx_gnt_o, w == 2);
        check("rx_gnt", rx_gnt_o, w == 3);
        check("bd_en", bd_en_o, w != 0);
        check("bd_wen", bd_wen_o, (w != 0) ? m_wen(w) : 1'b0);
        check("bd_addr", bd_addr_o, m_addr(w));
        check("bd_o", bd_o, m_wdata(w));
        if (cke) begin
            check("cpu_rvalid", cpu_rvalid_o, m_rv == 1);
            check("tx_rvalid", tx_rvalid_o, m_rv == 2);
            check("rx_rvalid", rx_rvalid_o, m_rv == 3);
            if (m_rv != 0) check("rdata", rdata_o, bd_i);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; tx_req = 0; rx_req = 0;
    endtask

    initial begin
        int exp_seq[10];
        cke = 1; arst_n = 0; bd_i = '0;
        cpu_wen = 0; tx_wen = 0; rx_wen = 0;
        cpu_addr = '0; tx_addr = '0; rx_addr = '0;
        cpu_wdata = '0; tx_wdata = '0; rx_wdata = '0;
        cpu_req = 1; tx_req = 1; rx_req = 1;

        // Reset: no grants even with every request high.
        repeat (2) @(negedge clk);
        check("rst_gnt", dut_gnt(), 0);
        check("rst_bd_en", bd_en_o, 0);
        check("rst_rvalid", {cpu_rvalid_o, tx_rvalid_o, rx_rvalid_o}, 3'b000);
        @(posedge clk); #1;
        arst_n = 1; idle();

        // CPU read of 0x05.
        cpu_req = 1; cpu_wen = 0; cpu_addr = 8'h05;
        @(negedge clk);
        check("r29_gnt", dut_gnt(), 1);
        check("r29_addr", bd_addr_o, 8'h05);
        next_cycle();
        cpu_req = 0; bd_i = 32'hDEADBEEF;
        @(negedge clk);
        check("r29_rvalid", cpu_rvalid_o, 1);
        check("r29_rdata", rdata_o, 32'hDEADBEEF);
        next_cycle();

        // TX write.
        tx_req = 1; tx_wen = 1; tx_addr = 8'h10; tx_wdata = 32'h12345678;
        @(negedge clk);
        check("r32_gnt", dut_gnt(), 2);
        check("r32_port", {bd_en_o, bd_wen_o, bd_addr_o, bd_o}, {1'b1, 1'b1, 8'h10, 32'h12345678});
        next_cycle();
        tx_req = 0; tx_wen = 0;
        @(negedge clk);
        check("r32_no_rvalid", tx_rvalid_o, 0);
        next_cycle();

        // TX/RX alternation starting from reset.
        arst_n = 0; #2; arst_n = 1;
        tx_req = 1; rx_req = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("r30_seq", dut_gnt(), (i % 2 == 0) ? 2 : 3);
            next_cycle();
        end

        // CPU vs TX: four CPU grants, then one TX.
        rx_req = 0; cpu_req = 1; cpu_wen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("r31_seq", dut_gnt(), (i % 5 == 4) ? 2 : 1);
            next_cycle();
        end

        // Freeze mid-run (run=2, TX served last); state must survive.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("r33_pre", dut_gnt(), 1);
            next_cycle();
        end
        cke = 0; rx_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("r33_frozen", {dut_gnt(), 31'(bd_en_o)}, 64'h0);
            next_cycle();
        end
        cke = 1;
        exp_seq[0] = 1; exp_seq[1] = 1; exp_seq[2] = 3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("r33_post", dut_gnt(), exp_seq[i]);
            next_cycle();
        end
        idle();
        next_cycle();

        // Reset right after a granted RX read.
        rx_req = 1; rx_wen = 0;
        @(negedge clk);
        check("r34_gnt", dut_gnt(), 3);
        next_cycle();
        rx_req = 0; arst_n = 0; #2; arst_n = 1;
        @(negedge clk);
        check("r34_rvalid", rx_rvalid_o, 0);
        next_cycle();
        tx_req = 1; rx_req = 1;
        @(negedge clk);
        check("r34_tx_first", dut_gnt(), 2);
        next_cycle();
        idle();

        // Mixed traffic, including dropped requests and short freezes.
        for (int i = 0; i < 80; i++) begin
            cpu_req = 1'($urandom); tx_req = 1'($urandom); rx_req = 1'($urandom);
            cpu_wen = 1'($urandom); tx_wen = 1'($urandom); rx_wen = 1'($urandom);
            cpu_addr = 8'($urandom); tx_addr = 8'($urandom); rx_addr = 8'($urandom);
            cpu_wdata = $urandom; tx_wdata = $urandom; rx_wdata = $urandom;
            bd_i = $urandom;
            cke = ($urandom_range(0, 7) != 0);
            next_cycle();
        end
        cke = 1; idle();
        repeat (3) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
